// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: default operand width,
// operation encodings, controller state encodings and a small decode helper.
// Optional build macro used by mdu_hilo: MDU_FAST_MULT_EN.
package mdu_pkg;

   // Default operand / HI / LO width; the iterative datapath takes this many steps.
   localparam int MDU_WIDTH = 32;

   // Operation encodings as presented on op_i.
   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   // Controller states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   // Signed variants treat operands as two's complement.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   // Bit 1 of the encoding selects the divide family.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative unsigned datapath for the multiply/divide unit.
// Operands are magnitudes; sign handling lives in the controller.
// Multiply: shift-add, multiplier held in the low register and shifted right,
//   the 2*WIDTH product ends up as {acc, mq}.
// Divide: restoring shift-subtract, dividend held in the low register and shifted
//   left, quotient bits enter from the right; acc holds the partial remainder.
// load_i captures the operands; each step_i cycle performs one iteration.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
)
(
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic                 div_i,
   input  logic [WIDTH-1:0]     a_mag_i,
   input  logic [WIDTH-1:0]     b_mag_i,
   output logic [2*WIDTH-1:0]   prod_o,
   output logic [WIDTH-1:0]     quot_o,
   output logic [WIDTH-1:0]     rem_o
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q,  mq_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             div_q, div_d;

   // One extra bit on the adder catches the carry (multiply) or borrow (divide).
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   add_sel;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // Next-state of the datapath: load, one iteration, or hold.
   always_comb begin
      acc_d   = acc_q;
      mq_d    = mq_q;
      opb_d   = opb_q;
      div_d   = div_q;

      // Multiply step: conditionally add multiplicand into the upper half.
      add_sum = {1'b0, acc_q} + {1'b0, opb_q};
      add_sel = mq_q[0] ? add_sum : {1'b0, acc_q};

      // Divide step: bring down the next dividend bit, trial-subtract divisor.
      // The remainder always stays below the divisor, so a clear top bit of
      // diff means the subtraction did not borrow.
      shifted = {acc_q, mq_q[WIDTH-1]};
      diff    = shifted - {1'b0, opb_q};

      if (load_i) begin
         acc_d = '0;
         mq_d  = a_mag_i;
         opb_d = b_mag_i;
         div_d = div_i;
      end else if (step_i) begin
         if (div_q) begin
            if (!diff[WIDTH]) begin
               acc_d = diff[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = add_sel[WIDTH:1];
            mq_d  = {add_sel[0], mq_q[WIDTH-1:1]};
         end
      end
   end

   // Datapath registers; cleared on reset so an aborted op leaves nothing behind.
   always_ff @(posedge clk) begin
      if (srst) begin
         acc_q <= '0;
         mq_q  <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         mq_q  <= mq_d;
         opb_q <= opb_d;
         div_q <= div_d;
      end
   end

   assign prod_o = {acc_q, mq_q};
   assign quot_o = mq_q;
   assign rem_o  = acc_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the single-cycle MIPS core.
// Controller: IDLE -> CALC (WIDTH iterations) -> FIX (sign correction, HI/LO
// write, done pulse) -> IDLE. Operands are reduced to magnitudes at start and
// the result signs are restored in FIX. Divide-by-zero and MTHI/MTLO writes are
// handled here; the iterations run in mdu_iter_core.
// Build macro MDU_FAST_MULT_EN: MULT/MULTU complete through a combinational
// multiplier at the start edge (no busy cycles); divides stay iterative.
// rst_n is a synchronous reset that is asserted high.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               hi_we_i,
   input  logic               lo_we_i,
   input  logic [WIDTH-1:0]   wd_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   // Controller state and registered outputs
   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Per-op context captured at start
   logic             div_q, div_d;          // divide family
   logic             neg_q, neg_d;          // product / quotient must be negated
   logic             neg_rem_q, neg_rem_d;  // remainder must be negated
   logic             dz_q, dz_d;            // divisor was zero
   logic [WIDTH-1:0] a_raw_q, a_raw_d;      // original dividend for divide-by-zero

   // Operand decode
   logic             op_signed;
   logic             op_div;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             start_iter;
   logic             core_load;
   logic             core_step;

   // Datapath results and their sign-corrected forms
   logic [2*WIDTH-1:0] core_prod;
   logic [WIDTH-1:0]   core_quot;
   logic [WIDTH-1:0]   core_rem;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

`ifdef MDU_FAST_MULT_EN
   logic               start_fast;
   logic [2*WIDTH-1:0] fast_mag;
   logic [2*WIDTH-1:0] fast_res;
`endif

   // Operand magnitudes and sign flags; also decides which path a start takes.
   always_comb begin
      op_signed = op_is_signed(op_i);
      op_div    = op_is_div(op_i);
      a_neg     = op_signed & a_i[WIDTH-1];
      b_neg     = op_signed & b_i[WIDTH-1];
      // The most negative value maps onto itself, which is the correct
      // unsigned magnitude.
      a_mag     = a_neg ? -a_i : a_i;
      b_mag     = b_neg ? -b_i : b_i;
`ifdef MDU_FAST_MULT_EN
      start_iter = start_i & op_div;
      start_fast = start_i & ~op_div;
      fast_mag   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
      fast_res   = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`else
      start_iter = start_i;
`endif
      core_load = (state_q == S_IDLE) && start_iter;
      core_step = (state_q == S_CALC);
   end

   mdu_iter_core #(
      .WIDTH   (WIDTH)
   ) u_core (
      .clk     (clk),
      .srst    (rst_n),
      .load_i  (core_load),
      .step_i  (core_step),
      .div_i   (op_div),
      .a_mag_i (a_mag),
      .b_mag_i (b_mag),
      .prod_o  (core_prod),
      .quot_o  (core_quot),
      .rem_o   (core_rem)
   );

   // Sign restoration of the unsigned datapath results.
   always_comb begin
      prod_fix = neg_q     ? -core_prod : core_prod;
      quot_fix = neg_q     ? -core_quot : core_quot;
      rem_fix  = neg_rem_q ? -core_rem  : core_rem;
   end

   // Controller next-state: op launch, iteration count, result write, MT writes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      div_d     = div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      a_raw_d   = a_raw_q;

      case (state_q)
         S_IDLE: begin
            if (start_iter) begin
               // A start takes priority over any concurrent MT write.
               div_d     = op_div;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dz_d      = op_div && (b_i == '0);
               a_raw_d   = a_i;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = S_CALC;
`ifdef MDU_FAST_MULT_EN
            end else if (start_fast) begin
               hi_d   = fast_res[2*WIDTH-1:WIDTH];
               lo_d   = fast_res[WIDTH-1:0];
               done_d = 1'b1;
`endif
            end else begin
               if (hi_we_i) begin
                  hi_d = wd_i;
               end
               if (lo_we_i) begin
                  lo_d = wd_i;
               end
            end
         end

         S_CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (dz_q) begin
               hi_d = a_raw_q;
               lo_d = '1;
            end else if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Controller registers; reset aborts any op in flight without touching HI/LO
   // beyond clearing them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         a_raw_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         a_raw_q   <= a_raw_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
